// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 bus sequencer: FSM states, register map, CTRL/STAT bits
// and the checksum helper.
package dht11_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStartLow,
    StRelease,
    StRespLow,
    StRespHigh,
    StBitLow,
    StBitHigh,
    StCheck
  } dht11_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_CKSUM  = 2'd2;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd3;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT   = 1;

  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_DONE_BIT  = 1;
  localparam int unsigned STAT_CKERR_BIT = 2;
  localparam int unsigned STAT_TMO_BIT   = 3;

  // Byte-wise sum of hum_int, hum_dec, temp_int, temp_dec, wrapping at 256.
  function automatic logic [7:0] dht11_sum(input logic [31:0] d);
    return d[31:24] + d[23:16] + d[15:8] + d[7:0];
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Prescaler producing a single-cycle tick once per DIV clocks (one per microsecond).
module dht11_us_tick #(
  parameter int unsigned DIV = 50
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // With DIV == 1 the counter sits at zero and tick is permanently high.
  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dht11_ctrl.sv
// DHT11 single-wire sequencer with Avalon-MM register file: start pulse, response and
// 40-bit frame timing, checksum verification, DONE/IRQ reporting.
module dht11_ctrl
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned BIT_THRESH_US = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  inout  wire         bidir_port
);

  localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned CNT_MAX  = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] START_LOW_CNT = CW'(START_LOW_US);
  localparam logic [CW-1:0] TIMEOUT_CNT   = CW'(TIMEOUT_US);
  localparam logic [CW-1:0] THRESH_CNT    = CW'(BIT_THRESH_US);

  dht11_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc, cnt_lim;
  logic [39:0]   shift_q, shift_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [31:0]   data_q, data_d;
  logic [7:0]    cksum_q, cksum_d;
  logic          done_q, done_d, ckerr_q, ckerr_d, tmo_q, tmo_d, irq_en_q, irq_en_d;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [31:0]   rdata_d;
  logic          tick, busy, rise, fall, timeout, abort, wr, wr_ctrl;
  logic          unused_wdata;

  dht11_us_tick #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // Open-drain: the line is only ever pulled low, and only during the start pulse.
  assign bidir_port = (state_q == StStartLow) ? 1'b0 : 1'bz;

  assign busy    = (state_q != StIdle);
  assign irq     = done_q & irq_en_q;
  assign rise    = sync_q[1] & ~prev_q;
  assign fall    = ~sync_q[1] & prev_q;
  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr && (address == ADDR_CTRL);
  assign unused_wdata = ^writedata[31:2];

  // Phase counter value including the current tick, saturating at the phase limit.
  assign cnt_lim = (state_q == StStartLow) ? START_LOW_CNT : TIMEOUT_CNT;
  assign cnt_inc = (tick && cnt_q != cnt_lim) ? cnt_q + 1'b1 : cnt_q;
  assign timeout = (cnt_inc == TIMEOUT_CNT);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    cksum_d   = cksum_q;
    done_d    = done_q;
    ckerr_d   = ckerr_q;
    tmo_d     = tmo_q;
    irq_en_d  = irq_en_q;
    abort     = 1'b0;

    if (wr && address == ADDR_IRQ_EN) begin
      irq_en_d = writedata[0];
    end
    if (wr_ctrl && writedata[CTRL_CLR_BIT]) begin
      done_d  = 1'b0;
      ckerr_d = 1'b0;
      tmo_d   = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (wr_ctrl && writedata[CTRL_START_BIT]) begin
          done_d    = 1'b0;
          ckerr_d   = 1'b0;
          tmo_d     = 1'b0;
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = StStartLow;
        end
      end
      StStartLow: begin
        if (cnt_inc == START_LOW_CNT) state_d = StRelease;
      end
      StRelease: begin
        if (fall) state_d = StRespLow;
        else      abort   = timeout;
      end
      StRespLow: begin
        if (rise) state_d = StRespHigh;
        else      abort   = timeout;
      end
      StRespHigh: begin
        if (fall) state_d = StBitLow;
        else      abort   = timeout;
      end
      StBitLow: begin
        if (rise) state_d = StBitHigh;
        else      abort   = timeout;
      end
      StBitHigh: begin
        if (fall) begin
          shift_d   = {shift_q[38:0], (cnt_inc >= THRESH_CNT)};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd39) ? StCheck : StBitLow;
        end else begin
          abort = timeout;
        end
      end
      StCheck: begin
        data_d  = shift_q[39:8];
        cksum_d = shift_q[7:0];
        ckerr_d = (dht11_sum(shift_q[39:8]) != shift_q[7:0]);
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      tmo_d   = 1'b1;
      done_d  = 1'b1;
      state_d = StIdle;
    end
  end

  // Counter restarts on every state entry; idle keeps it parked at zero.
  assign cnt_d = (state_d != state_q || state_q == StIdle) ? '0 : cnt_inc;

  always_comb begin
    rdata_d = '0;
    unique case (address)
      ADDR_CTRL: begin
        rdata_d[STAT_BUSY_BIT]  = busy;
        rdata_d[STAT_DONE_BIT]  = done_q;
        rdata_d[STAT_CKERR_BIT] = ckerr_q;
        rdata_d[STAT_TMO_BIT]   = tmo_q;
      end
      ADDR_DATA:   rdata_d = data_q;
      ADDR_CKSUM:  rdata_d[7:0] = cksum_q;
      ADDR_IRQ_EN: rdata_d[0] = irq_en_q;
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      cksum_q   <= '0;
      done_q    <= 1'b0;
      ckerr_q   <= 1'b0;
      tmo_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      readdata  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      cksum_q   <= cksum_d;
      done_q    <= done_d;
      ckerr_q   <= ckerr_d;
      tmo_q     <= tmo_d;
      irq_en_q  <= irq_en_d;
      sync_q    <= {sync_q[0], bidir_port};
      prev_q    <= sync_q[1];
      readdata  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dht11_ctrl.sv
// Directed bench for dht11_ctrl: Avalon register access plus a DHT11 sensor model on a
// pulled-up open-drain line. One tick per clock; shortened start pulse keeps runtime small.
module tb_dht11_ctrl;

  localparam int unsigned START_LOW = 2000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic        sensor_low = 1'b0;
  wire         dht_line;

  int n_checks = 0;
  int n_fail = 0;

  pullup (dht_line);
  assign dht_line = sensor_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  dht11_ctrl #(
    .CLK_FREQ_HZ  (1_000_000),
    .START_LOW_US (START_LOW),
    .TIMEOUT_US   (200),
    .BIT_THRESH_US(40)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .bidir_port(dht_line)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    @(negedge clk);
    check(tag, readdata, exp);
  endtask

  task automatic wait_release();
    int n = 0;
    while (dht_line !== 1'b1 && n < START_LOW + 100) begin
      @(negedge clk);
      n++;
    end
    check("line_released", {31'b0, dht_line}, 32'h1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    @(negedge clk);
    address = 2'd0;
    @(negedge clk);
    @(negedge clk);
    while (readdata[0] !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'b0, readdata[0]}, 32'h0);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    sensor_low = 1'b0;
    reset_n = 1'b0;
    #1;
    check({tag, "_rdata"}, readdata, 32'h0);
    check({tag, "_irq"}, {31'b0, irq}, 32'h0);
    check({tag, "_line"}, {31'b0, dht_line}, 32'h1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Sensor side of one transaction; abort_at < 40 asserts reset mid-way through that bit's high.
  task automatic sensor_frame(input logic [39:0] frame, input int w0, input int w1,
                              input int abort_at);
    wait_release();
    repeat (30) @(negedge clk);
    sensor_low = 1'b1;
    repeat (80) @(negedge clk);
    sensor_low = 1'b0;
    repeat (80) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      int w;
      sensor_low = 1'b1;
      repeat (50) @(negedge clk);
      sensor_low = 1'b0;
      w = frame[39-i] ? w1 : w0;
      if (i == abort_at) begin
        repeat (w / 2) @(negedge clk);
        reset_pulse("abort");
        return;
      end
      repeat (w) @(negedge clk);
    end
    sensor_low = 1'b1;
    repeat (50) @(negedge clk);
    sensor_low = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int low_cycles;

    // Reset state
    reset_pulse("reset");
    read_check("rst_stat", 2'd0, 32'h0);
    read_check("rst_data", 2'd1, 32'h0);
    read_check("rst_cksum", 2'd2, 32'h0);
    read_check("rst_irqen", 2'd3, 32'h0);

    // 1: good frame, 26/70 us bits, interrupt enabled
    write_reg(2'd3, 32'h1);
    read_check("irqen_rb", 2'd3, 32'h1);
    write_reg(2'd0, 32'h1);
    sensor_frame(40'h35_00_18_00_4D, 26, 70, 40);
    wait_idle(500);
    read_check("t1_data", 2'd1, 32'h3500_1800);
    read_check("t1_cksum", 2'd2, 32'h4D);
    read_check("t1_stat", 2'd0, 32'h2);
    check("t1_irq", {31'b0, irq}, 32'h1);
    check("t1_line", {31'b0, dht_line}, 32'h1);

    // 2: CLR, then bad checksum
    write_reg(2'd0, 32'h2);
    read_check("t2_clr_stat", 2'd0, 32'h0);
    check("t2_clr_irq", {31'b0, irq}, 32'h0);
    write_reg(2'd0, 32'h1);
    sensor_frame(40'h35_00_18_00_4E, 26, 70, 40);
    wait_idle(500);
    read_check("t2_data", 2'd1, 32'h3500_1800);
    read_check("t2_cksum", 2'd2, 32'h4E);
    read_check("t2_stat", 2'd0, 32'h6);

    // 3: no sensor response
    write_reg(2'd0, 32'h1);
    wait_release();
    wait_idle(400);
    read_check("t3_stat", 2'd0, 32'hA);
    read_check("t3_data", 2'd1, 32'h3500_1800);
    check("t3_line", {31'b0, dht_line}, 32'h1);
    check("t3_irq", {31'b0, irq}, 32'h1);

    // 4: threshold boundary widths 39 -> 0, 40 -> 1
    write_reg(2'd0, 32'h1);
    sensor_frame(40'hA5_3C_0F_F0_E0, 39, 40, 40);
    wait_idle(500);
    read_check("t4_data", 2'd1, 32'hA53C_0FF0);
    read_check("t4_cksum", 2'd2, 32'hE0);
    read_check("t4_stat", 2'd0, 32'h2);

    // 5: START and CLR during the start pulse
    write_reg(2'd0, 32'h1);
    low_cycles = 0;
    while (dht_line === 1'b0 && low_cycles < START_LOW + 100) begin
      low_cycles++;
      if (low_cycles == 100 || low_cycles == 200) begin
        chipselect = 1'b1; write_n = 1'b0;
        writedata = (low_cycles == 100) ? 32'h1 : 32'h2;
      end else begin
        chipselect = 1'b0; write_n = 1'b1;
      end
      if (low_cycles == 150 || low_cycles == 300) begin
        check("t5_busy", {31'b0, readdata[0]}, 32'h1);
      end
      @(negedge clk);
    end
    check("t5_low_len", low_cycles, START_LOW);
    sensor_frame(40'h2A_00_17_05_46, 26, 70, 40);
    wait_idle(500);
    read_check("t5_data", 2'd1, 32'h2A00_1705);
    read_check("t5_stat", 2'd0, 32'h2);

    // 6: reset during a data bit high, then a clean transfer
    write_reg(2'd0, 32'h1);
    sensor_frame(40'h35_00_18_00_4D, 26, 70, 10);
    read_check("t6_stat", 2'd0, 32'h0);
    read_check("t6_data", 2'd1, 32'h0);
    read_check("t6_cksum", 2'd2, 32'h0);
    read_check("t6_irqen", 2'd3, 32'h0);
    write_reg(2'd0, 32'h1);
    sensor_frame(40'h35_00_18_00_4D, 26, 70, 40);
    wait_idle(500);
    read_check("t6b_data", 2'd1, 32'h3500_1800);
    read_check("t6b_stat", 2'd0, 32'h2);
    check("t6b_irq", {31'b0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
